mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 200 ++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Brief    : Load/store sequencer with byte-lane steering, optional two-beat
//            split of boundary-crossing accesses, and load sign/zero extension.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int DATA_W           = 32,
    parameter int ADDR_W           = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    input  logic                i_is_store,
    input  logic [1:0]          i_size,
    input  logic                i_unsigned,
    input  logic [ADDR_W-1:0]   rs1_val,
    input  logic [ADDR_W-1:0]   imm,
    input  logic [DATA_W-1:0]   rs2_val,
    output logic                stall_pc,
    output logic                ignore_curr_inst,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [DATA_W-1:0]   load_data,
    output logic                load_valid,
    output logic                misalign_err
);

    localparam int         NB    = DATA_W / 8;
    localparam int         OFS_W = $clog2(NB);
    localparam logic [4:0] C_NB  = 5'(NB);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ0  = 3'd1;
    localparam logic [2:0] S_WAIT0 = 3'd2;
    localparam logic [2:0] S_REQ1  = 3'd3;
    localparam logic [2:0] S_WAIT1 = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]          r_state, w_next;
    logic [ADDR_W-1:0]   r_base;
    logic [OFS_W-1:0]    r_ofs;
    logic [3:0]          r_nbytes;
    logic [1:0]          r_size;
    logic                r_store, r_unsigned, r_cross, r_err;
    logic [DATA_W-1:0]   r_wdata;
    logic [2*DATA_W-1:0] r_rbuf;

    logic [ADDR_W-1:0]   w_ea;
    logic [3:0]          w_in_nbytes;
    logic [4:0]          w_in_end, w_end, w_nb_left;
    logic                w_in_cross, w_in_err;
    logic [NB-1:0]       w_be0, w_be1;
    logic [DATA_W-1:0]   w_mask0, w_mask1, w_wdata0, w_wdata1, w_raw, w_ext;
    logic                w_sign, w_fill;

    assign w_ea        = rs1_val + imm;
    assign w_in_nbytes = 4'd1 << i_size;
    assign w_in_end    = 5'(w_ea[OFS_W-1:0]) + 5'(w_in_nbytes);
    assign w_in_cross  = w_in_end > C_NB;
    // A dword on a 32-bit bus can never be issued, split or not.
    assign w_in_err    = (w_in_cross && !SPLIT_MISALIGNED) || (i_size == 2'd3 && DATA_W < 64);

    assign w_end     = 5'(r_ofs) + 5'(r_nbytes);
    assign w_nb_left = C_NB - 5'(r_ofs);
    assign w_wdata0  = r_wdata << {r_ofs, 3'b000};
    assign w_wdata1  = r_wdata >> {w_nb_left, 3'b000};
    // Beat1 bytes sit just above beat0 in r_rbuf, so one shift re-justifies.
    assign w_raw     = DATA_W'(r_rbuf >> {r_ofs, 3'b000});

    always_comb begin
        w_be0   = '0;
        w_be1   = '0;
        w_mask0 = '0;
        w_mask1 = '0;
        for (int i = 0; i < NB; i++) begin
            w_be0[i]           = (5'(i) >= 5'(r_ofs)) && (5'(i) < w_end);
            w_be1[i]           = (5'(i) + C_NB) < w_end;
            w_mask0[8*i +: 8]  = {8{w_be0[i]}};
            w_mask1[8*i +: 8]  = {8{w_be1[i]}};
        end
    end

    always_comb begin
        w_ext = '0;
        case (r_size)
            2'd0:    w_sign = w_raw[7];
            2'd1:    w_sign = w_raw[15];
            2'd2:    w_sign = w_raw[31];
            default: w_sign = w_raw[DATA_W-1];
        endcase
        w_fill = w_sign & ~r_unsigned;
        for (int i = 0; i < DATA_W; i++) begin
            w_ext[i] = (i < 8 * int'(r_nbytes)) ? w_raw[i] : w_fill;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_base     <= '0;
            r_ofs      <= '0;
            r_nbytes   <= '0;
            r_size     <= '0;
            r_store    <= 1'b0;
            r_unsigned <= 1'b0;
            r_cross    <= 1'b0;
            r_err      <= 1'b0;
            r_wdata    <= '0;
            r_rbuf     <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && i_valid) begin
                r_base     <= {w_ea[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                r_ofs      <= w_ea[OFS_W-1:0];
                r_nbytes   <= w_in_nbytes;
                r_size     <= i_size;
                r_store    <= i_is_store;
                r_unsigned <= i_unsigned;
                r_cross    <= w_in_cross;
                r_err      <= w_in_err;
                r_wdata    <= rs2_val;
                r_rbuf     <= '0;
            end
            if (r_state == S_WAIT0 && mem_rvalid)
                r_rbuf[DATA_W-1:0] <= mem_rdata & w_mask0;
            if (r_state == S_WAIT1 && mem_rvalid)
                r_rbuf[2*DATA_W-1:DATA_W] <= mem_rdata & w_mask1;
        end
    end

    always_comb begin
        w_next           = r_state;
        stall_pc         = 1'b0;
        ignore_curr_inst = 1'b0;
        mem_req          = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        mem_be           = '0;
        load_data        = '0;
        load_valid       = 1'b0;
        misalign_err     = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall_pc = i_valid && !i_rst;
                if (i_valid)
                    w_next = w_in_err ? S_DONE : S_REQ0;
            end
            S_REQ0: begin
                stall_pc  = 1'b1;
                mem_req   = 1'b1;
                mem_we    = r_store;
                mem_addr  = r_base;
                mem_be    = w_be0;
                mem_wdata = w_wdata0;
                if (mem_gnt)
                    w_next = r_store ? (r_cross ? S_REQ1 : S_DONE) : S_WAIT0;
            end
            S_WAIT0: begin
                stall_pc = 1'b1;
                if (mem_rvalid)
                    w_next = r_cross ? S_REQ1 : S_DONE;
            end
            S_REQ1: begin
                stall_pc  = 1'b1;
                mem_req   = 1'b1;
                mem_we    = r_store;
                mem_addr  = r_base + ADDR_W'(NB);
                mem_be    = w_be1;
                mem_wdata = w_wdata1;
                if (mem_gnt)
                    w_next = r_store ? S_DONE : S_WAIT1;
            end
            S_WAIT1: begin
                stall_pc = 1'b1;
                if (mem_rvalid)
                    w_next = S_DONE;
            end
            S_DONE: begin
                ignore_curr_inst = 1'b1;
                misalign_err     = r_err;
                load_valid       = !r_store && !r_err;
                load_data        = (!r_store && !r_err) ? w_ext : '0;
                w_next           = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed self-checking bench; split and non-split instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0, valid0 = 1'b0, is_store = 1'b0, uns = 1'b0;
    logic [1:0]  size = '0;
    logic [31:0] rs1 = '0, imm = '0, rs2 = '0, rdata = '0;
    logic        gnt = 1'b0, rvalid = 1'b0;
    logic        gnt0 = 1'b0, rvalid0 = 1'b0;

    logic        stall, ign, req, we, lv, err;
    logic [31:0] addr, wdata, ld;
    logic [3:0]  be;
    logic        stall0, ign0, req0, we0, lv0, err0;
    logic [31:0] addr0, wdata0, ld0;
    logic [3:0]  be0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_is_store(is_store), .i_size(size),
        .i_unsigned(uns), .rs1_val(rs1), .imm(imm), .rs2_val(rs2),
        .stall_pc(stall), .ignore_curr_inst(ign), .mem_req(req), .mem_we(we),
        .mem_addr(addr), .mem_wdata(wdata), .mem_be(be), .mem_gnt(gnt),
        .mem_rvalid(rvalid), .mem_rdata(rdata), .load_data(ld), .load_valid(lv),
        .misalign_err(err));

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(valid0), .i_is_store(is_store), .i_size(size),
        .i_unsigned(uns), .rs1_val(rs1), .imm(imm), .rs2_val(rs2),
        .stall_pc(stall0), .ignore_curr_inst(ign0), .mem_req(req0), .mem_we(we0),
        .mem_addr(addr0), .mem_wdata(wdata0), .mem_be(be0), .mem_gnt(gnt0),
        .mem_rvalid(rvalid0), .mem_rdata(rdata), .load_data(ld0), .load_valid(lv0),
        .misalign_err(err0));

    task automatic step();
        @(negedge clk);
    endtask

    task automatic set_op(input logic st, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] d);
        is_store = st; size = sz; uns = u; rs1 = a; imm = b; rs2 = d;
    endtask

    // Non-crossing load with immediate grant and data; returns at DONE (+1).
    task automatic run_load(input logic [1:0] sz, input logic u, input logic [31:0] a,
                            input logic [31:0] d);
        step(); set_op(1'b0, sz, u, a, 32'd0, 32'd0); valid = 1'b1; gnt = 1'b1;
        step(); valid = 1'b0;
        step(); rvalid = 1'b1; rdata = d;
        step(); rvalid = 1'b0; gnt = 1'b0; #1;
    endtask

    task automatic test_reset();
        step(); valid = 1'b1; #1;
        checks++; if ({stall, ign, req, we, lv, err} !== 6'b0) begin errors++;
            $display("FAIL reset_ctrl: got %b expected 000000", {stall, ign, req, we, lv, err}); end
        checks++; if ({addr, wdata, be, ld} !== 100'b0) begin errors++;
            $display("FAIL reset_data: addr %h wdata %h be %h ld %h expected all 0", addr, wdata, be, ld); end
        valid = 1'b0;
        step(); rst = 1'b0;
    endtask

    task automatic test_sw_aligned();
        step(); set_op(1'b1, 2'd2, 1'b0, 32'h1000, 32'd4, 32'hDEADBEEF); valid = 1'b1; gnt = 1'b1; #1;
        checks++; if (stall !== 1'b1 || req !== 1'b0) begin errors++;
            $display("FAIL sw_accept: stall %b req %b expected 1 0", stall, req); end
        step(); valid = 1'b0; #1;
        checks++; if ({req, we, addr, be, wdata} !== {1'b1, 1'b1, 32'h1004, 4'hF, 32'hDEADBEEF}) begin errors++;
            $display("FAIL sw_beat: req %b we %b addr %h be %h wdata %h expected 1 1 1004 f deadbeef", req, we, addr, be, wdata); end
        step(); #1;
        checks++; if ({ign, stall, req, lv, err} !== 5'b10000) begin errors++;
            $display("FAIL sw_done: ign/stall/req/lv/err %b expected 10000", {ign, stall, req, lv, err}); end
        step(); gnt = 1'b0; #1;
        checks++; if (ign !== 1'b0 || stall !== 1'b0) begin errors++;
            $display("FAIL sw_idle: ign %b stall %b expected 0 0", ign, stall); end
    endtask

    task automatic test_sb_wait_gnt();
        step(); set_op(1'b1, 2'd0, 1'b0, 32'h1000, 32'd3, 32'h000000A5); valid = 1'b1;
        step(); valid = 1'b0; #1;
        checks++; if ({req, addr, be, wdata} !== {1'b1, 32'h1000, 4'h8, 32'hA5000000}) begin errors++;
            $display("FAIL sb_beat: req %b addr %h be %h wdata %h expected 1 1000 8 a5000000", req, addr, be, wdata); end
        step(); #1;
        checks++; if ({req, stall, addr, be, wdata} !== {2'b11, 32'h1000, 4'h8, 32'hA5000000}) begin errors++;
            $display("FAIL sb_hold: req %b stall %b addr %h be %h wdata %h expected held", req, stall, addr, be, wdata); end
        gnt = 1'b1;
        step(); gnt = 1'b0; #1;
        checks++; if (ign !== 1'b1) begin errors++;
            $display("FAIL sb_done: ign %b expected 1", ign); end
    endtask

    task automatic test_lw_split();
        step(); set_op(1'b0, 2'd2, 1'b0, 32'h2000, 32'd2, 32'd0); valid = 1'b1; gnt = 1'b1;
        step(); valid = 1'b0; #1;
        checks++; if ({req, we, addr, be} !== {1'b1, 1'b0, 32'h2000, 4'hC}) begin errors++;
            $display("FAIL lw_beat0: req %b we %b addr %h be %h expected 1 0 2000 c", req, we, addr, be); end
        step(); #1;
        checks++; if ({req, be, stall} !== {1'b0, 4'h0, 1'b1}) begin errors++;
            $display("FAIL lw_wait0: req %b be %h stall %b expected 0 0 1", req, be, stall); end
        rvalid = 1'b1; rdata = 32'h11223344;
        step(); rvalid = 1'b0; rdata = 32'hFFFFFFFF; #1;
        checks++; if ({req, addr, be} !== {1'b1, 32'h2004, 4'h3}) begin errors++;
            $display("FAIL lw_beat1: req %b addr %h be %h expected 1 2004 3", req, addr, be); end
        step(); rvalid = 1'b1; rdata = 32'h55667788;
        step(); rvalid = 1'b0; gnt = 1'b0; #1;
        checks++; if ({lv, ign, stall, ld} !== {3'b110, 32'h77881122}) begin errors++;
            $display("FAIL lw_result: lv %b ign %b stall %b data %h expected 1 1 0 77881122", lv, ign, stall, ld); end
        step();
    endtask

    task automatic test_lb_ext();
        run_load(2'd0, 1'b0, 32'h3001, 32'h00008000);
        checks++; if (lv !== 1'b1 || ld !== 32'hFFFFFF80) begin errors++;
            $display("FAIL lb_signed: lv %b data %h expected 1 ffffff80", lv, ld); end
        step();
        run_load(2'd0, 1'b1, 32'h3001, 32'h00008000);
        checks++; if (ld !== 32'h00000080) begin errors++;
            $display("FAIL lbu: data %h expected 00000080", ld); end
        step();
        run_load(2'd1, 1'b0, 32'h3002, 32'h9ABC0000);
        checks++; if (ld !== 32'hFFFF9ABC) begin errors++;
            $display("FAIL lh_signed: data %h expected ffff9abc", ld); end
        step();
    endtask

    task automatic test_misalign_nosplit();
        step(); set_op(1'b1, 2'd1, 1'b0, 32'h4000, 32'd3, 32'h0000BEEF); valid0 = 1'b1; #1;
        checks++; if (stall0 !== 1'b1) begin errors++;
            $display("FAIL ms_accept: stall %b expected 1", stall0); end
        step(); valid0 = 1'b0; #1;
        checks++; if ({req0, err0, ign0, stall0, lv0} !== 5'b01100) begin errors++;
            $display("FAIL ms_done: req/err/ign/stall/lv %b expected 01100", {req0, err0, ign0, stall0, lv0}); end
        step(); #1;
        checks++; if ({req0, err0, ign0} !== 3'b000) begin errors++;
            $display("FAIL ms_after: req/err/ign %b expected 000", {req0, err0, ign0}); end
    endtask

    task automatic test_split_store(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                                    input logic [1:0] sz, input logic [31:0] a0, input logic [3:0] e0,
                                    input logic [31:0] w0, input logic [31:0] a1, input logic [3:0] e1,
                                    input logic [31:0] w1);
        step(); set_op(1'b1, sz, 1'b0, a, b, d); valid = 1'b1; gnt = 1'b1;
        step(); valid = 1'b0; #1;
        checks++; if ({req, addr, be, wdata} !== {1'b1, a0, e0, w0}) begin errors++;
            $display("FAIL st_beat0: req %b addr %h be %h wdata %h expected 1 %h %h %h", req, addr, be, wdata, a0, e0, w0); end
        step(); #1;
        checks++; if ({req, addr, be, wdata} !== {1'b1, a1, e1, w1}) begin errors++;
            $display("FAIL st_beat1: req %b addr %h be %h wdata %h expected 1 %h %h %h", req, addr, be, wdata, a1, e1, w1); end
        step(); gnt = 1'b0; #1;
        checks++; if ({ign, err, req} !== 3'b100) begin errors++;
            $display("FAIL st_done: ign/err/req %b expected 100", {ign, err, req}); end
        step();
    endtask

    task automatic test_reset_mid_op();
        step(); set_op(1'b0, 2'd2, 1'b0, 32'h5000, 32'd0, 32'd0); valid = 1'b1; gnt = 1'b1;
        step(); valid = 1'b0;
        step(); gnt = 1'b0; #1;
        checks++; if (stall !== 1'b1 || req !== 1'b0) begin errors++;
            $display("FAIL rm_wait0: stall %b req %b expected 1 0", stall, req); end
        rst = 1'b1; #1;
        checks++; if ({stall, ign, req, we, lv, err, be, addr, wdata, ld} !== 106'b0) begin errors++;
            $display("FAIL rm_reset: stall %b req %b addr %h wdata %h be %h expected all 0", stall, req, addr, wdata, be); end
        step(); rst = 1'b0; rvalid = 1'b1; rdata = 32'h12345678;
        step(); rvalid = 1'b0; #1;
        checks++; if ({lv, ign, stall, req} !== 4'b0) begin errors++;
            $display("FAIL rm_late_rvalid: lv/ign/stall/req %b expected 0000", {lv, ign, stall, req}); end
        step(); #1;
        checks++; if ({lv, ign, stall} !== 3'b0) begin errors++;
            $display("FAIL rm_idle: lv/ign/stall %b expected 000", {lv, ign, stall}); end
    endtask

    initial begin
        test_reset();
        test_sw_aligned();
        test_sb_wait_gnt();
        test_lw_split();
        test_lb_ext();
        test_misalign_nosplit();
        test_split_store(32'h4000, 32'd3, 32'h0000BEEF, 2'd1,
                         32'h4000, 4'h8, 32'hEF000000, 32'h4004, 4'h1, 32'h000000BE);
        test_split_store(32'hFFFFFFF0, 32'hE, 32'h12345678, 2'd2,
                         32'hFFFFFFFC, 4'hC, 32'h56780000, 32'h00000000, 4'h3, 32'h00001234);
        test_reset_mid_op();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
